// File: rtl/sort_pkg.sv
// Shared definitions for the sort blocks: loader FSM state type and padding fill.
package sort_pkg;

  // Loader FSM states; 3-bit encoding leaves spare codes that are trapped as illegal.
  typedef enum logic [2:0] {
    FILL  = 3'd0,
    DRAIN = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3
  } loader_state_e;

  // Padding bit replicated across unwritten slots so short frames sort to the top.
  localparam logic PAD_BIT = 1'b1;

endpackage

// File: rtl/sort_loader.sv
// Streams words into a packed frame for the sorter, starts it, and waits for completion.
module sort_loader
  import sort_pkg::*;
#(
  parameter int INPUTVALS      = 16,
  parameter int INPUTBITWIDTHS = 32
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [INPUTBITWIDTHS-1:0]                    in_data,
  input  logic                                         in_valid,
  input  logic                                         in_last,
  output logic                                         in_ready,
  output logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]     needs_sorting,
  output logic                                         sortstart,
  input  logic                                         sortdone,
  output logic [$clog2(INPUTVALS):0]                   frame_count,
  output logic                                         error
);

  localparam int CW = $clog2(INPUTVALS) + 1;
  localparam logic [INPUTBITWIDTHS-1:0] PAD_WORD = {INPUTBITWIDTHS{PAD_BIT}};

  loader_state_e                               state_q, state_d;
  logic [CW-1:0]                               idx_q, idx_d;
  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]    needs_sorting_q, needs_sorting_d;
  logic [CW-1:0]                               frame_count_q, frame_count_d;
  logic                                        sortstart_q, sortstart_d;
  logic                                        error_q, error_d;
  logic                                        xfer;

  // Ready is a pure state decode so it never depends on in_valid.
  always_comb begin
    in_ready = (state_q == FILL) || (state_q == DRAIN);
    xfer     = in_valid && in_ready;
  end

  // Next-state, frame write and pulse generation.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    needs_sorting_d = needs_sorting_q;
    frame_count_d   = frame_count_q;
    error_d         = 1'b0;
    case (state_q)
      FILL: begin
        if (xfer) begin
          for (int unsigned i = 0; i < INPUTVALS; i++) begin
            if (idx_q == CW'(i)) needs_sorting_d[i] = in_data;
          end
          idx_d = idx_q + CW'(1);
          if (in_last) begin
            frame_count_d = idx_q + CW'(1);
            state_d       = START;
          end else if (idx_q == CW'(INPUTVALS - 1)) begin
            frame_count_d = CW'(INPUTVALS);
            error_d       = 1'b1;
            state_d       = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (xfer && in_last) state_d = START;
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (sortdone) begin
          state_d         = FILL;
          idx_d           = '0;
          needs_sorting_d = {INPUTVALS{PAD_WORD}};
        end
      end
      default: begin
        state_d         = FILL;
        idx_d           = '0;
        needs_sorting_d = {INPUTVALS{PAD_WORD}};
        frame_count_d   = '0;
        error_d         = 1'b1;
      end
    endcase
    // Registered start pulse: asserted exactly while the register holds START.
    sortstart_d = (state_d == START);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= FILL;
      idx_q           <= '0;
      needs_sorting_q <= {INPUTVALS{PAD_WORD}};
      frame_count_q   <= '0;
      sortstart_q     <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      needs_sorting_q <= needs_sorting_d;
      frame_count_q   <= frame_count_d;
      sortstart_q     <= sortstart_d;
      error_q         <= error_d;
    end
  end

  assign needs_sorting = needs_sorting_q;
  assign frame_count   = frame_count_q;
  assign sortstart     = sortstart_q;
  assign error         = error_q;

endmodule

// File: tb/tb_sort_loader.sv
// Scoreboard bench for sort_loader: driver pushes expected frames, monitor checks at sortstart.
module tb_sort_loader;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = $clog2(N) + 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [W-1:0]         in_data;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [N-1:0][W-1:0]  needs_sorting;
  logic                 sortstart;
  logic                 sortdone;
  logic [CW-1:0]        frame_count;
  logic                 error;

  always #5 clk = ~clk;

  sort_loader #(.INPUTVALS(N), .INPUTBITWIDTHS(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .needs_sorting (needs_sorting),
    .sortstart     (sortstart),
    .sortdone      (sortdone),
    .frame_count   (frame_count),
    .error         (error)
  );

  typedef struct {
    logic [N-1:0][W-1:0] ns;
    int unsigned         cnt;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   cur;
  int     checks   = 0;
  int     failures = 0;
  bit     waiting  = 1'b0;
  logic   prev_ss  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: first min(len,N) words land in order, the rest are all-ones padding.
  function automatic exp_t model(input logic [W-1:0] ws[$]);
    exp_t e;
    e.cnt = (ws.size() < N) ? ws.size() : N;
    for (int k = 0; k < N; k++) e.ns[k] = (k < ws.size()) ? ws[k] : {W{1'b1}};
    return e;
  endfunction

  // Monitor: pops an expectation on each sortstart and checks the frame stays put until sortdone.
  always @(negedge clk) begin
    if (!reset) begin
      if (sortstart) begin
        chk("sortstart_width", {63'b0, prev_ss}, 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_sortstart", 64'd1, 64'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("frame_data", {32'b0, needs_sorting}, {32'b0, cur.ns});
          chk("frame_count", {61'b0, frame_count}, 64'(cur.cnt));
          chk("ready_low_start", {63'b0, in_ready}, 64'd0);
          waiting = 1'b1;
        end
      end else if (waiting) begin
        chk("hold_stable", {32'b0, needs_sorting}, {32'b0, cur.ns});
      end
    end
    prev_ss = sortstart;
  end

  task automatic send_frame(input logic [W-1:0] ws[$], input bit gaps);
    bit acc;
    int unsigned tmo;
    exp_q.push_back(model(ws));
    for (int i = 0; i < ws.size(); i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_data  = ws[i];
      in_last  = (i == ws.size() - 1);
      sortdone = ($urandom_range(0, 3) == 0);
      acc = 1'b0;
      tmo = 0;
      while (!acc && tmo < 50) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        tmo++;
      end
      if (!acc) begin
        chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        sortdone = 1'b0;
        return;
      end
      chk("error_pulse", {63'b0, error}, {63'b0, (i == N - 1) && (ws.size() > N)});
    end
    chk("latency_sortstart", {63'b0, sortstart}, 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    sortdone = 1'b0;
  endtask

  task automatic complete_sort(input int unsigned hold, input bit hold_valid);
    in_valid = hold_valid;
    for (int unsigned c = 0; c < hold; c++) begin
      @(negedge clk);
      chk("no_ready_in_wait", {63'b0, in_ready}, 64'd0);
    end
    @(posedge clk); #1;
    sortdone = 1'b1;
    @(posedge clk); #1;
    sortdone = 1'b0;
    in_valid = 1'b0;
    waiting  = 1'b0;
    chk("ready_after_done", {63'b0, in_ready}, 64'd1);
    chk("pad_after_done", {32'b0, needs_sorting}, {32'b0, {N{8'hFF}}});
  endtask

  initial begin
    logic [W-1:0] ws[$];
    int unsigned  len;
    int unsigned  tmo;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    sortdone = 1'b0;
    @(posedge clk); #1;
    chk("ready_during_reset", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_sortstart", {63'b0, sortstart}, 64'd0);
    chk("rst_error", {63'b0, error}, 64'd0);
    chk("rst_frame", {32'b0, needs_sorting}, {32'b0, {N{8'hFF}}});
    chk("rst_count", {61'b0, frame_count}, 64'd0);
    @(posedge clk); #1;

    ws = '{8'h10, 8'h05, 8'h30, 8'h02};
    send_frame(ws, 1'b0);
    complete_sort(3, 1'b0);

    ws = '{8'h07, 8'h03};
    send_frame(ws, 1'b0);
    complete_sort(20, 1'b1);

    ws = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_frame(ws, 1'b0);
    complete_sort(2, 1'b0);

    // Abort a frame after two words with reset.
    in_valid = 1'b1;
    in_last  = 1'b0;
    in_data  = 8'h55;
    @(posedge clk); #1;
    in_data  = 8'h66;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_frame", {32'b0, needs_sorting}, {32'b0, {N{8'hFF}}});
    chk("midrst_count", {61'b0, frame_count}, 64'd0);
    chk("midrst_ready", {63'b0, in_ready}, 64'd1);
    chk("midrst_error", {63'b0, error}, 64'd0);

    ws = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_frame(ws, 1'b0);
    complete_sort(1, 1'b1);

    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 7);
      ws.delete();
      for (int unsigned k = 0; k < len; k++) ws.push_back(W'($urandom));
      send_frame(ws, 1'b1);
      complete_sort($urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    tmo = 0;
    while (exp_q.size() != 0 && tmo < 20) begin
      @(posedge clk);
      tmo++;
    end
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/sort_loader.md
SORT_LOADER -- requirements
Module: sort_loader

Interface
REQ-001 The block SHALL have parameter INPUTVALS, default 16, meaning the number of words per sort frame.
REQ-002 The block SHALL have parameter INPUTBITWIDTHS, default 32, meaning the width of one word.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic rises on posedge clk.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_data, input, INPUTBITWIDTHS bits: the streamed word.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 The block SHALL have port in_last, input, 1 bit: the current word is the last word of the frame.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-009 The block SHALL have port needs_sorting, output, [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]: the packed frame for the sorter.
REQ-010 The block SHALL have port sortstart, output, 1 bit: a one-cycle pulse that starts the sorter.
REQ-011 The block SHALL have port sortdone, input, 1 bit: the sorter-finished pulse.
REQ-012 The block SHALL have port frame_count, output, $clog2(INPUTVALS)+1 bits: the number of real words in the latched frame.
REQ-013 The block SHALL have port error, output, 1 bit: a one-cycle pulse on frame overflow or an illegal state.

Function
REQ-014 The FSM SHALL have the states FILL, DRAIN, START and WAIT.
REQ-015 A transfer SHALL occur only in a cycle where in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL be 1 in FILL and DRAIN and 0 in START and WAIT; it is decoded from the state register only.
REQ-017 In FILL, each transfer SHALL write in_data to needs_sorting[idx], where idx is the write index (0 at frame start), and then increment idx.
REQ-018 In FILL, a transfer with in_last=1 SHALL latch frame_count=idx+1 and go to START.
REQ-019 In FILL, a transfer at idx=INPUTVALS-1 with in_last=0 SHALL:
- latch frame_count=INPUTVALS;
- pulse error for one cycle;
- go to DRAIN.
REQ-020 In DRAIN, the block SHALL discard every transfer and leave needs_sorting unchanged; a transfer with in_last=1 SHALL go to START.
REQ-021 Slots that FILL does not write SHALL hold all-ones, so that a short frame's padding sorts to the top positions.
REQ-022 START SHALL last exactly one cycle, with sortstart=1, and then go to WAIT.
REQ-023 sortstart SHALL be registered and SHALL be 1 only in the START cycle.
REQ-024 needs_sorting SHALL be held stable from the START cycle until sortdone is seen.
REQ-025 In WAIT, sortdone=1 SHALL return the FSM to FILL and, in the same edge, set every needs_sorting slot to all-ones and idx to 0.
REQ-026 sortdone outside WAIT SHALL be ignored.
REQ-027 An in_last=1 transfer at idx=INPUTVALS-1 SHALL be a full frame: go to START, with no error.
REQ-028 An illegal state encoding SHALL:
- pulse error;
- reinitialise as in reset;
- go to FILL.
REQ-029 Latency SHALL be one cycle: from the last-word transfer edge to sortstart=1.

Reset
REQ-030 On reset=1 at posedge clk, from any state including mid-frame or WAIT, the block SHALL set:
- state=FILL and idx=0;
- needs_sorting all-ones;
- frame_count=0, sortstart=0, error=0.
REQ-031 During reset, in_ready SHALL follow the state decode and SHALL be 1 in the first cycle after reset.

Structure
REQ-032 A shared package sort_pkg SHALL hold the loader state enum typedef and the padding constant (all-ones), for reuse by the sort blocks.
REQ-033 The block SHALL be a single module with no sub-module; the idx counter and the FSM are inline.

Verification (INPUTVALS=4, INPUTBITWIDTHS=8)
REQ-034 Reset release -> in_ready=1, sortstart=0, error=0, needs_sorting=FF,FF,FF,FF, frame_count=0.
REQ-035 Send 0x10,0x05,0x30,0x02, with last on 0x02 -> sortstart pulses one cycle after the last transfer; needs_sorting[0..3]=10,05,30,02; frame_count=4; error=0.
REQ-036 Send 0x07,0x03, with last on 0x03 -> needs_sorting=07,03,FF,FF; frame_count=2; in_ready=0 until sortdone.
REQ-037 Send 6 words 1..6, last on 6 -> error pulse at the 4th transfer; needs_sorting=01,02,03,04; words 5 and 6 accepted and dropped; sortstart follows the transfer of 6.
REQ-038 In WAIT, hold in_valid=1 for 20 cycles, then pulse sortdone -> no transfers before sortdone; in_ready=1 the next cycle; needs_sorting all FF.
REQ-039 Assert reset after 2 words of a frame -> idx=0 and needs_sorting all FF; a new 4-word frame then loads correctly.
